// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one signed add/sub unit.
// Registered result stage tagged with requester id and op type.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqX_valid/ready           per-requester handshake (X = 0,1)
//   reqX_a/b/sub               signed operands and op (1 = A-B)
//   res_valid/ready            result handshake
//   res_data (N+1), res_id, res_sub
//   ops_done (CNT_W)           wrapping count of consumed results
// Optional: define ADDSUB_SAT_EN to clamp the result to the signed
// N-bit range and add the res_sat output.
module addsub_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N:0]       res_data,
  output logic             res_id,
  output logic             res_sub,
  output logic [CNT_W-1:0] ops_done
`ifdef ADDSUB_SAT_EN
  ,
  output logic             res_sat
`endif
);

  logic             res_valid_q, res_valid_d;
  logic [N:0]       res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             res_sub_q, res_sub_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic             load;
  logic             gnt0, gnt1;
  logic             xfer;
  logic             sel;
  logic [N-1:0]     op_a, op_b;
  logic             op_sub;
  logic [N:0]       a_x, b_x;
  logic [N:0]       sum;
  logic [N:0]       res_new;

  assign load = ~res_valid_q | res_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid): begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end
      (req0_valid & ~req1_valid): gnt0 = 1'b1;
      (~req0_valid & req1_valid): gnt1 = 1'b1;
      default: ;
    endcase
  end

  // Readies are forced low while reset is held.
  assign req0_ready = rst_n & load & gnt0;
  assign req1_ready = rst_n & load & gnt1;

  assign xfer   = req0_ready | req1_ready;
  assign sel    = req1_ready;
  assign op_a   = sel ? req1_a : req0_a;
  assign op_b   = sel ? req1_b : req0_b;
  assign op_sub = sel ? req1_sub : req0_sub;

  // One extra bit of headroom means the sum never overflows.
  assign a_x = {op_a[N-1], op_a};
  assign b_x = {op_b[N-1], op_b};
  assign sum = op_sub ? (a_x - b_x) : (a_x + b_x);

`ifdef ADDSUB_SAT_EN
  logic sat_q, sat_d;
  logic ovf;

  // Top two bits disagree -> value outside the N-bit signed range.
  assign ovf = sum[N] ^ sum[N-1];

  always_comb begin
    res_new = sum;
    if (ovf) begin
      res_new = sum[N] ? {2'b11, {(N-1){1'b0}}}
                       : {2'b00, {(N-1){1'b1}}};
    end
  end
`else
  assign res_new = sum;
`endif

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_sub_d   = res_sub_q;
    prio_d      = prio_q;
    ops_d       = ops_q;
`ifdef ADDSUB_SAT_EN
    sat_d       = sat_q;
`endif
    if (res_valid_q & res_ready) begin
      ops_d       = ops_q + CNT_W'(1);
      res_valid_d = 1'b0;
    end
    // A new result overrides the drain in the same edge.
    if (xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = res_new;
      res_id_d    = sel;
      res_sub_d   = op_sub;
      prio_d      = ~sel;
`ifdef ADDSUB_SAT_EN
      sat_d       = ovf;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_sub_q   <= 1'b0;
      prio_q      <= 1'b0;
      ops_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_sub_q   <= res_sub_d;
      prio_q      <= prio_d;
      ops_q       <= ops_d;
    end
  end

`ifdef ADDSUB_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign res_sat = sat_q;
`endif

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_sub   = res_sub_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter.
// Random and directed stimulus against a behavioural model.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 0, v1 = 0, s0 = 0, s1 = 0, rr = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;

  logic        r0, r1, rv, rid, rsub;
  logic [4:0]  rd;
  logic [15:0] ops;
  logic        r0b, r1b, rvb, ridb, rsubb;
  logic [4:0]  rdb;
  logic [1:0]  opsb;
`ifdef ADDSUB_SAT_EN
  logic rsat, rsatb;
`endif

  addsub_arbiter #(.N(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0),
    .req0_a(a0), .req0_b(b0), .req0_sub(s0),
    .req1_valid(v1), .req1_ready(r1),
    .req1_a(a1), .req1_b(b1), .req1_sub(s1),
    .res_valid(rv), .res_ready(rr),
    .res_data(rd), .res_id(rid), .res_sub(rsub),
    .ops_done(ops)
`ifdef ADDSUB_SAT_EN
    , .res_sat(rsat)
`endif
  );

  addsub_arbiter #(.N(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0b),
    .req0_a(a0), .req0_b(b0), .req0_sub(s0),
    .req1_valid(v1), .req1_ready(r1b),
    .req1_a(a1), .req1_b(b1), .req1_sub(s1),
    .res_valid(rvb), .res_ready(rr),
    .res_data(rdb), .res_id(ridb), .res_sub(rsubb),
    .ops_done(opsb)
`ifdef ADDSUB_SAT_EN
    , .res_sat(rsatb)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_vld, m_data, m_id, m_sub, m_ops, m_prio;
`ifdef ADDSUB_SAT_EN
  int m_sat;
`endif

  function automatic int sx(logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // -1 none, else requester index
  function automatic int exp_grant();
    if (v0 && v1) return m_prio;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit exp_load();
    return (m_vld == 0) || rr;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = 0; m_id = 0;
    m_sub = 0; m_ops = 0; m_prio = 0;
`ifdef ADDSUB_SAT_EN
    m_sat = 0;
`endif
  endtask

  task automatic model_edge();
    int g, a, b, r, sb;
    bit ld;
    g = exp_grant();
    ld = exp_load();
    if (m_vld != 0 && rr) begin
      m_ops++;
      m_vld = 0;
    end
    if (ld && g >= 0) begin
      a  = (g == 1) ? sx(a1) : sx(a0);
      b  = (g == 1) ? sx(b1) : sx(b0);
      sb = (g == 1) ? int'(s1) : int'(s0);
      r  = (sb != 0) ? a - b : a + b;
`ifdef ADDSUB_SAT_EN
      m_sat = 0;
      if (r > 7) begin r = 7; m_sat = 1; end
      else if (r < -8) begin r = -8; m_sat = 1; end
`endif
      m_data = r;
      m_id = g;
      m_sub = sb;
      m_vld = 1;
      m_prio = 1 - g;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 0;
    v0 = 0; v1 = 0; rr = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    v0 = 1; v1 = 1; rr = 1;
    #3;
    checks++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", r0, r1);
    end
    checks++;
    if (rv !== 1'b0 || rd !== 5'd0 || rid !== 1'b0 ||
        rsub !== 1'b0 || ops !== 16'd0) begin
      errors++;
      $display("FAIL reset_out: got v%b d%h i%b s%b o%0d expected zeros",
               rv, rd, rid, rsub, ops);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    v0 = 1; a0 = 4'd3; b0 = 4'd2; s0 = 0; rr = 1;
    #1;
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready: got %b%b expected 10", r0, r1);
    end
    tick();
    v0 = 0;
    checks++;
    if (rv !== 1'b1 || rd !== 5'd5 || rid !== 1'b0 || rsub !== 1'b0) begin
      errors++;
      $display("FAIL basic_res: got v%b d%0d i%b s%b expected v1 d5 i0 s0",
               rv, rd, rid, rsub);
    end
    tick();
    checks++;
    if (ops !== 16'd1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL basic_ops: got o%0d v%b expected o1 v0", ops, rv);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] e;
    do_reset();
    v0 = 1; a0 = 4'd7; b0 = 4'd7; s0 = 0;
    v1 = 1; a1 = 4'b1000; b1 = 4'd1; s1 = 1;
    rr = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef ADDSUB_SAT_EN
      e = (i % 2 == 0) ? 5'b00111 : 5'b11000;
      checks++;
      if (rsat !== 1'b1) begin
        errors++;
        $display("FAIL alt_sat[%0d]: got %b expected 1", i, rsat);
      end
`else
      e = (i % 2 == 0) ? 5'b01110 : 5'b10111;
`endif
      checks++;
      if (rid !== 1'(i % 2) || rd !== e || rv !== 1'b1 ||
          ops !== 16'(m_ops)) begin
        errors++;
        $display("FAIL alt[%0d]: got i%b d%h o%0d expected i%0d d%h o%0d",
                 i, rid, rd, ops, i % 2, e, m_ops);
      end
    end
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    v0 = 1; a0 = 4'd2; b0 = 4'd1; s0 = 1; rr = 0;
    tick();
    v0 = 0;
    v1 = 1; a1 = 4'd5; b1 = 4'd6; s1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (r1 !== 1'b0 || r0 !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b%b expected 00", i, r0, r1);
      end
      tick();
      checks++;
      if (rd !== 5'd1 || rv !== 1'b1 || rid !== 1'b0 || rsub !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v%b d%0d i%b s%b expected v1 d1 i0 s1",
                 i, rv, rd, rid, rsub);
      end
    end
    rr = 1;
    #1;
    checks++;
    if (r1 !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got %b expected 1", r1);
    end
    tick();
    v1 = 0;
    checks++;
    if (rid !== 1'b1 || rd !== 5'(m_data) || rv !== 1'b1 || ops !== 16'd1) begin
      errors++;
      $display("FAIL stall_new: got i%b d%h o%0d expected i1 d%h o1",
               rid, rd, ops, 5'(m_data));
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    v1 = 1; a1 = 4'd1; b1 = 4'd1; s1 = 0; rr = 1;
    #1;
    checks++;
    if (r1 !== 1'b1 || r0 !== 1'b0) begin
      errors++;
      $display("FAIL prio_only1: got %b%b expected 01", r0, r1);
    end
    tick();
    v0 = 1; a0 = 4'd2; b0 = 4'd3; s0 = 0;
    #1;
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL prio_both: got %b%b expected 10", r0, r1);
    end
    tick();
    checks++;
    if (rid !== 1'b0 || rd !== 5'd5) begin
      errors++;
      $display("FAIL prio_res: got i%b d%0d expected i0 d5", rid, rd);
    end
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    v0 = 1; rr = 1;
    for (int i = 0; i < 6; i++) begin
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      s0 = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (ops !== 16'd5 || rv !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got o%0d v%b expected o5 v1", ops, rv);
    end
    v1 = 1; rr = 0;
    #1 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rv !== 1'b0 || ops !== 16'd0 || rd !== 5'd0) begin
      errors++;
      $display("FAIL arst_clear: got v%b o%0d d%h expected v0 o0 d0",
               rv, ops, rd);
    end
    #3 rst_n = 1;
    #1;
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_prio: got %b%b expected 10", r0, r1);
    end
    tick();
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_wrap();
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    do_reset();
    v0 = 1; a0 = 4'd1; b0 = 4'd1; s0 = 0; rr = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (opsb !== 2'(exp_seq[i]) || ops !== 16'(i + 1)) begin
        errors++;
        $display("FAIL wrap[%0d]: got %0d/%0d expected %0d/%0d",
                 i, opsb, ops, exp_seq[i], i + 1);
      end
    end
    v0 = 0;
    tick();
  endtask

  task automatic test_random();
    bit e0, e1;
    int g;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant();
      e0 = exp_load() && g == 0;
      e1 = exp_load() && g == 1;
      checks++;
      if (r0 !== e0 || r1 !== e1 || r0b !== e0 || r1b !== e1) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b",
                 i, r0, r1, e0, e1);
      end
      tick();
      checks++;
      if (rv !== 1'(m_vld) || rd !== 5'(m_data) || rid !== 1'(m_id) ||
          rsub !== 1'(m_sub) || ops !== 16'(m_ops) ||
          opsb !== 2'(m_ops) || rvb !== rv || rdb !== 5'(m_data) ||
          ridb !== 1'(m_id) || rsubb !== 1'(m_sub)) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got v%b d%h i%b s%b o%0d expected v%0d d%h i%0d s%0d o%0d",
                 i, rv, rd, rid, rsub, ops, m_vld, 5'(m_data),
                 m_id, m_sub, m_ops);
      end
`ifdef ADDSUB_SAT_EN
      checks++;
      if (rsat !== 1'(m_sat) || rsatb !== 1'(m_sat)) begin
        errors++;
        $display("FAIL rnd_sat[%0d]: got %b expected %0d", i, rsat, m_sat);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_alternate();
    test_stall();
    test_priority();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
